tile_wr_scheduler: RTL and testbench



---
 rtl/tile_pkg.sv | 28 ++
 rtl/tile_wr_scheduler_if.sv | 18 +
 rtl/tile_wr_scheduler_rr_arbiter8.sv | 35 +++
 rtl/tile_wr_scheduler.sv | 209 ++++++++++++++++++++
 tb/tb_tile_wr_scheduler.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/tile_pkg.sv
// Shared definitions for the tile write scheduler slice.
//   - memory geometry (AW, DW, N_TILES)
//   - display timing constant SCREEN_Y (first blanking line)
//   - synchronizer depth default
//   - RGB111 colour constants
//   - FSM state encoding (legacy-style localparam constants)
//   - next_colour(): colour increment with natural wrap (7 -> 0)
package tile_pkg;

  localparam int AW          = 3;
  localparam int DW          = 3;
  localparam int N_TILES     = 8;
  localparam int SCREEN_Y    = 480;
  localparam int SYNC_STAGES = 2;

  localparam logic [DW-1:0] BLACK = 3'b000;
  localparam logic [DW-1:0] WHITE = 3'b111;
  localparam logic [DW-1:0] RED   = 3'b100;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_CLEAR = 2'd2;

  function automatic logic [DW-1:0] next_colour(input logic [DW-1:0] c);
    return c + DW'(1);
  endfunction

endpackage

// File: rtl/tile_wr_scheduler_if.sv
// Tile colour RAM write port.
//   mem_addr : write address (AW bits)
//   mem_data : write data (DW bits)
//   mem_we   : write strobe
// Handshake: write-only, no back-pressure. mem_we is a one-cycle pulse per
// write; mem_addr/mem_data are valid only while mem_we is high and otherwise
// hold their last value. The RAM must accept a write on every cycle.
interface tile_wr_scheduler_if #(
  parameter int AW = 3,
  parameter int DW = 3
);
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          mem_we;

  modport master (output mem_addr, output mem_data, output mem_we);
  modport slave  (input  mem_addr, input  mem_data, input  mem_we);
endinterface

// File: rtl/tile_wr_scheduler_rr_arbiter8.sv
// rr_arbiter8: combinational round-robin pick over 8 requesters.
//   req       : request bits
//   ptr       : index with highest priority this round
//   grant_oh  : one-hot grant
//   grant_idx : index of the grant
//   valid     : any request present
// The search starts at ptr and wraps modulo 8.
module rr_arbiter8
  import tile_pkg::*;
(
  input  logic [N_TILES-1:0] req,
  input  logic [2:0]         ptr,
  output logic [N_TILES-1:0] grant_oh,
  output logic [2:0]         grant_idx,
  output logic               valid
);

  logic [2:0] cand;

  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    valid     = 1'b0;
    cand      = '0;
    for (int i = 0; i < N_TILES; i++) begin
      cand = ptr + 3'(i);
      if (!valid && req[cand]) begin
        valid          = 1'b1;
        grant_idx      = cand;
        grant_oh[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tile_wr_scheduler.sv
// tile_wr_scheduler: sequences writes into the 8-entry tile colour RAM.
// Eight switch requesters (any toggle) and a clear button (rising edge) are
// synchronized, latched as pending requests and served only during vertical
// blanking, so a visible frame never shows a half-updated tile set.
// Ports:
//   clk, rst    : pixel clock, asynchronous active-high reset
//   sw          : tile toggle switches (async)
//   clr         : clear button (async, active-high)
//   vga_posY    : current VGA line
//   mem         : RAM write port (master side)
//   busy        : FSM active or any request pending
//   tile_colors : shadow of all tile colours, tile i at [DW*i +: DW]
//   dbg_state   : current FSM state
module tile_wr_scheduler #(
  parameter int AW          = tile_pkg::AW,
  parameter int DW          = tile_pkg::DW,
  parameter int SCREEN_Y    = tile_pkg::SCREEN_Y,
  parameter int SYNC_STAGES = tile_pkg::SYNC_STAGES
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 sw,
  input  logic                       clr,
  input  logic [8:0]                 vga_posY,
  tile_wr_scheduler_if.master        mem,
  output logic                       busy,
  output logic [8*DW-1:0]            tile_colors,
  output logic [1:0]                 dbg_state
);

  import tile_pkg::ST_IDLE;
  import tile_pkg::ST_WRITE;
  import tile_pkg::ST_CLEAR;

  localparam int         ARM_CYCLES = SYNC_STAGES + 1;
  localparam logic [8:0] BLANK_LINE = 9'(SCREEN_Y);

  // ---------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------
  logic [SYNC_STAGES-1:0][7:0] sw_sync;
  logic [7:0]                  sw_prev;
  logic [SYNC_STAGES-1:0]      clr_sync;
  logic                        clr_prev;
  logic [7:0]                  arm_cnt;
  logic                        armed;
  logic [7:0]                  sw_edge;
  logic                        clr_edge;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_sync  <= '0;
      sw_prev  <= '0;
      clr_sync <= '0;
      clr_prev <= 1'b0;
    end else begin
      sw_sync[0]  <= sw;
      clr_sync[0] <= clr;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sw_sync[i]  <= sw_sync[i-1];
        clr_sync[i] <= clr_sync[i-1];
      end
      sw_prev  <= sw_sync[SYNC_STAGES-1];
      clr_prev <= clr_sync[SYNC_STAGES-1];
    end
  end

  // The synchronizer chain starts at zero, so a switch held high through
  // reset looks like a toggle while it walks down the chain. Edges are
  // ignored until the chain and the previous-value flop have settled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arm_cnt <= '0;
    end else if (!armed) begin
      arm_cnt <= arm_cnt + 8'd1;
    end
  end

  assign armed    = (arm_cnt == 8'(ARM_CYCLES));
  assign sw_edge  = armed ? (sw_sync[SYNC_STAGES-1] ^ sw_prev) : 8'h00;
  assign clr_edge = armed & clr_sync[SYNC_STAGES-1] & ~clr_prev;

  // ---------------------------------------------------------------------
  // Blanking detect, registered (decisions use it one cycle late)
  // ---------------------------------------------------------------------
  logic vblank;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) vblank <= 1'b0;
    else     vblank <= (vga_posY >= BLANK_LINE);
  end

  // ---------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------
  logic [7:0]    pend;
  logic          clr_pend;
  logic [2:0]    rr_ptr;
  logic [7:0]    arb_oh;
  logic [2:0]    arb_idx;
  logic          arb_valid;

  rr_arbiter8 u_arb (
    .req       (pend),
    .ptr       (rr_ptr),
    .grant_oh  (arb_oh),
    .grant_idx (arb_idx),
    .valid     (arb_valid)
  );

  // ---------------------------------------------------------------------
  // Scheduler FSM, write port and shadow colours
  // ---------------------------------------------------------------------
  logic [1:0]    state;
  logic [AW-1:0] cnt;
  logic [AW-1:0] g;
  logic [7:0]    g_oh;
  logic          clr_again;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_data_q;
  logic          mem_we_q;
  logic [DW-1:0] shadow [8];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      g          <= '0;
      g_oh       <= '0;
      clr_again  <= 1'b0;
      pend       <= '0;
      clr_pend   <= 1'b0;
      rr_ptr     <= '0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      mem_we_q   <= 1'b0;
      for (int i = 0; i < 8; i++) shadow[i] <= '0;
    end else begin
      // New edges always land, including on the tile being written now.
      pend     <= pend | sw_edge;
      clr_pend <= clr_pend | clr_edge;

      case (state)
        ST_IDLE: begin
          mem_we_q <= 1'b0;
          if (vblank && clr_pend) begin
            state      <= ST_CLEAR;
            cnt        <= '0;
            clr_again  <= 1'b0;
            mem_we_q   <= 1'b1;
            mem_addr_q <= '0;
            mem_data_q <= tile_pkg::BLACK;
          end else if (vblank && arb_valid) begin
            state      <= ST_WRITE;
            g          <= AW'(arb_idx);
            g_oh       <= arb_oh;
            mem_we_q   <= 1'b1;
            mem_addr_q <= AW'(arb_idx);
            mem_data_q <= tile_pkg::next_colour(shadow[arb_idx]);
          end
        end

        ST_WRITE: begin
          mem_we_q  <= 1'b0;
          shadow[g] <= mem_data_q;
          pend      <= (pend & ~g_oh) | sw_edge;
          rr_ptr    <= 3'(g + AW'(1));
          state     <= ST_IDLE;
        end

        ST_CLEAR: begin
          shadow[cnt] <= tile_pkg::BLACK;
          // A clear press arriving mid-clear is served by a later clear.
          if (clr_edge) clr_again <= 1'b1;
          if (cnt == '1) begin
            mem_we_q <= 1'b0;
            pend     <= sw_edge;
            clr_pend <= clr_again | clr_edge;
            rr_ptr   <= '0;
            state    <= ST_IDLE;
          end else begin
            cnt        <= cnt + AW'(1);
            mem_we_q   <= 1'b1;
            mem_addr_q <= cnt + AW'(1);
            mem_data_q <= tile_pkg::BLACK;
          end
        end

        default: begin
          mem_we_q <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem.mem_addr = mem_addr_q;
  assign mem.mem_data = mem_data_q;
  assign mem.mem_we   = mem_we_q;

  always_comb begin
    tile_colors = '0;
    for (int i = 0; i < 8; i++) tile_colors[DW*i +: DW] = shadow[i];
  end

  assign busy      = (state != ST_IDLE) | (|pend) | clr_pend;
  assign dbg_state = state;

endmodule

// File: tb/tb_tile_wr_scheduler.sv
module tb_tile_wr_scheduler;
  import tile_pkg::*;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] sw;
  logic       clr;
  logic [8:0] posy;
  logic       busy;
  logic [23:0] tile_colors;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  tile_wr_scheduler_if #(.AW(3), .DW(3)) mem_if ();

  tile_wr_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .sw          (sw),
    .clr         (clr),
    .vga_posY    (posy),
    .mem         (mem_if.master),
    .busy        (busy),
    .tile_colors (tile_colors),
    .dbg_state   (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wr_total = 0;
  int unexpected_wr = 0;
  logic [5:0] exp_q[$];
  int wr_cyc_q[$];
  logic [2:0] model_col [8];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: every write strobe is matched against the expected queue.
  always @(negedge clk) begin
    if (!rst && mem_if.mem_we) begin
      wr_total++;
      wr_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        unexpected_wr++;
      end else begin
        check("wr_addr_data", {26'd0, mem_if.mem_addr, mem_if.mem_data}, {26'd0, exp_q.pop_front()});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) model_col[i] = 3'd0;
  endtask

  task automatic push_write(input int t);
    model_col[t] = model_col[t] + 3'd1;
    exp_q.push_back({3'(t), model_col[t]});
  endtask

  task automatic push_clear_entry(input int a);
    model_col[a] = 3'd0;
    exp_q.push_back({3'(a), 3'd0});
  endtask

  function automatic logic [23:0] pack_model();
    logic [23:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[3*i +: 3] = model_col[i];
    return r;
  endfunction

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, (n < budget) ? 32'd1 : 32'd0, 32'd1);
    idle(1);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    int wr_mark;
    int n;
    model_reset();
    rst = 1'b1; sw = 8'h00; clr = 1'b0; posy = 9'd100;
    repeat (3) @(negedge clk);
    check("rst_we",    mem_if.mem_we, 0);
    check("rst_addr",  mem_if.mem_addr, 0);
    check("rst_data",  mem_if.mem_data, 0);
    check("rst_busy",  busy, 0);
    check("rst_tiles", tile_colors, 0);
    check("rst_state", dbg_state, ST_IDLE);
    @(posedge clk); #1 rst = 1'b0;
    idle(6);

    // single toggle held off while visible, written in blanking
    sw[3] = 1'b1; push_write(3);
    idle(12);
    check("t1_held_visible", exp_q.size(), 1);
    check("t1_busy", busy, 1);
    posy = 9'd490;
    drain("t1_drain", 40);
    check("t1_tile3", tile_colors[11:9], 1);

    // repeated toggles walk the colour through its wrap
    for (int k = 0; k < 7; k++) begin
      sw[3] = ~sw[3]; push_write(3);
      drain("t2_drain", 40);
    end
    check("t2_tile3_wrap", tile_colors[11:9], 0);
    check("t2_shadow", tile_colors, pack_model());

    // preload two tiles; pointer sits at 4, so 6 is served before 1
    sw = sw | 8'h42; push_write(6); push_write(1);
    drain("pre_drain", 40);
    check("pre_shadow", tile_colors, pack_model());

    // clear with a pending tile request
    posy = 9'd100; idle(2);
    wr_mark = wr_total;
    sw[5] = 1'b1; clr = 1'b1; idle(2); clr = 1'b0; idle(10);
    check("t4_no_wr_visible", wr_total - wr_mark, 0);
    check("t4_busy", busy, 1);
    for (int a = 0; a < 8; a++) push_clear_entry(a);
    wr_cyc_q.delete();
    posy = 9'd490;
    drain("t4_drain", 60);
    check("t4_burst_len", wr_cyc_q.size(), 8);
    if (wr_cyc_q.size() == 8) check("t4_burst_span", wr_cyc_q[7] - wr_cyc_q[0], 7);
    check("t4_tiles_zero", tile_colors, 0);
    wr_mark = wr_total;
    idle(10);
    check("t4_pend5_dropped", wr_total - wr_mark, 0);
    check("t4_idle_busy", busy, 0);

    // three simultaneous requests from pointer 0
    posy = 9'd100; idle(2);
    sw = sw ^ 8'h85; push_write(0); push_write(2); push_write(7);
    idle(6);
    wr_cyc_q.delete();
    posy = 9'd490;
    drain("t3_drain", 40);
    check("t3_count", wr_cyc_q.size(), 3);
    if (wr_cyc_q.size() == 3) begin
      check("t3_gap0", wr_cyc_q[1] - wr_cyc_q[0], 2);
      check("t3_gap1", wr_cyc_q[2] - wr_cyc_q[1], 2);
    end
    // pointer wrapped to 0: tile 0 wins over tile 7
    sw = sw ^ 8'h81; push_write(0); push_write(7);
    drain("t3_wrap_drain", 40);
    check("t3_shadow", tile_colors, pack_model());

    // switch held through reset release raises nothing
    rst = 1'b1; sw = 8'h02; clr = 1'b0; model_reset();
    idle(3);
    rst = 1'b0;
    wr_mark = wr_total;
    idle(15);
    check("t5_no_req", wr_total - wr_mark, 0);
    check("t5_busy", busy, 0);
    check("t5_tiles", tile_colors, 0);
    sw[1] = 1'b0; push_write(1);
    drain("t5_drain", 40);
    check("t5_tile1", tile_colors, pack_model());

    // reset in the 4th cycle of a clear
    for (int a = 0; a < 4; a++) push_clear_entry(a);
    clr = 1'b1;
    n = 0;
    @(negedge clk);
    while (dbg_state != ST_CLEAR && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("t6_clear_start", (n < 40) ? 32'd1 : 32'd0, 32'd1);
    repeat (3) @(negedge clk);
    #1 rst = 1'b1; clr = 1'b0;
    #1;
    check("t6_we_low", mem_if.mem_we, 0);
    check("t6_tiles", tile_colors, 0);
    check("t6_busy", busy, 0);
    check("t6_state", dbg_state, ST_IDLE);
    check("t6_exp_used", exp_q.size(), 0);
    model_reset();
    exp_q.delete();
    idle(2);
    rst = 1'b0;
    wr_mark = wr_total;
    idle(20);
    check("t6_no_writes", wr_total - wr_mark, 0);
    check("t6_busy_after", busy, 0);

    check("unexpected_writes", unexpected_wr, 0);
    check("exp_q_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
